// File: rtl/cache_ctrl_nway_if.sv
// Datapath and memory-side signal bundle for cache_ctrl_nway.
// The cache uses the slave modport; the datapath/memory side uses master.
interface cache_ctrl_nway_if;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore, hit_count, miss_count
    );

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore, hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back/write-allocate data cache with true-LRU
// replacement, halt-triggered dirty flush and hit/miss counters.
module cache_ctrl_nway #(
    parameter int WAYS  = 2,
    parameter int SETS  = 8,
    parameter int WORDS = 4
) (
    input logic              CLK,
    input logic              nRST,
    cache_ctrl_nway_if.slave bus
);
    localparam int BB = $clog2(WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 32 - 2 - BB - IB;
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {COMPARE, WB, FILL, FLUSH, FLUSHED} state_t;

    state_t state;

    logic          valid [SETS][WAYS];
    logic          dirty [SETS][WAYS];
    logic [TB-1:0] tag   [SETS][WAYS];
    logic [WW-1:0] age   [SETS][WAYS];
    logic [31:0]   data  [SETS][WAYS][WORDS];

    logic [IB-1:0] line_idx;
    logic [WW-1:0] line_way;
    logic [BB-1:0] beat;
    logic [TB-1:0] fill_tag;
    logic          retry;
    logic [31:0]   hit_cnt, miss_cnt;

    logic [TB-1:0] req_tag;
    logic [IB-1:0] req_idx;
    logic [BB-1:0] req_off;
    logic          req, hit, vic_found, line_dirty, wb_active;
    logic          last_beat, last_way, last_set, flush_step;
    logic [WW-1:0] hit_way, vic_way;
    logic          unused_addr;

    assign req_tag     = bus.dmemaddr[31 -: TB];
    assign req_idx     = bus.dmemaddr[2+BB +: IB];
    assign req_off     = bus.dmemaddr[2 +: BB];
    assign unused_addr = ^bus.dmemaddr[1:0];
    assign req         = bus.dmemREN | bus.dmemWEN;

    // Tag compare and victim choice: lowest invalid way, else the LRU way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_way   = '0;
        vic_found = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tag[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!valid[req_idx][w] && !vic_found) begin
                vic_way   = WW'(w);
                vic_found = 1'b1;
            end
        end
        if (!vic_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age[req_idx][w] == WW'(WAYS - 1)) vic_way = WW'(w);
            end
        end
    end

    assign line_dirty = valid[line_idx][line_way] && dirty[line_idx][line_way];
    assign wb_active  = (state == WB) || (state == FLUSH && line_dirty);
    assign last_beat  = (beat == BB'(WORDS - 1));
    assign last_way   = (line_way == WW'(WAYS - 1));
    assign last_set   = (line_idx == IB'(SETS - 1));
    assign flush_step = (state == FLUSH) && (!line_dirty || (!bus.dwait && last_beat));

    assign bus.dhit       = (state == COMPARE) && req && hit;
    assign bus.dmemload   = (bus.dhit && !bus.dmemWEN) ? data[req_idx][hit_way][req_off] : '0;
    assign bus.flushed    = (state == FLUSHED);
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // Memory port depends only on registered state, so it holds steady across dwait.
    always_comb begin
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        if (wb_active) begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {tag[line_idx][line_way], line_idx, beat, 2'b00};
            bus.dstore = data[line_idx][line_way][beat];
        end else if (state == FILL) begin
            bus.dREN  = 1'b1;
            bus.daddr = {fill_tag, line_idx, beat, 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= COMPARE;
            line_idx <= '0;
            line_way <= '0;
            beat     <= '0;
            fill_tag <= '0;
            retry    <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tag[s][w]   <= '0;
                    age[s][w]   <= WW'(w);
                    for (int unsigned k = 0; k < WORDS; k++) data[s][w][k] <= '0;
                end
            end
        end else begin
            case (state)
                COMPARE: begin
                    if (req && hit) begin
                        if (bus.dmemWEN) begin
                            data[req_idx][hit_way][req_off] <= bus.dmemstore;
                            dirty[req_idx][hit_way]         <= 1'b1;
                        end
                        for (int unsigned w = 0; w < WAYS; w++) begin
                            if (age[req_idx][w] < age[req_idx][hit_way])
                                age[req_idx][w] <= age[req_idx][w] + 1'b1;
                        end
                        age[req_idx][hit_way] <= '0;
                        if (!retry) hit_cnt <= hit_cnt + 1;
                        retry <= 1'b0;
                    end else if (req) begin
                        miss_cnt <= miss_cnt + 1;
                        retry    <= 1'b1;
                        line_idx <= req_idx;
                        line_way <= vic_way;
                        fill_tag <= req_tag;
                        beat     <= '0;
                        state    <= (valid[req_idx][vic_way] && dirty[req_idx][vic_way]) ? WB : FILL;
                    end else if (bus.halt) begin
                        line_idx <= '0;
                        line_way <= '0;
                        beat     <= '0;
                        state    <= FLUSH;
                    end
                end
                WB: begin
                    if (!bus.dwait) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) state <= FILL;
                    end
                end
                FILL: begin
                    if (!bus.dwait) begin
                        data[line_idx][line_way][beat] <= bus.dload;
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) begin
                            tag[line_idx][line_way]   <= fill_tag;
                            valid[line_idx][line_way] <= 1'b1;
                            dirty[line_idx][line_way] <= 1'b0;
                            state                     <= COMPARE;
                        end
                    end
                end
                FLUSH: begin
                    if (line_dirty && !bus.dwait) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                        if (last_beat) dirty[line_idx][line_way] <= 1'b0;
                    end
                    if (flush_step) begin
                        line_way <= last_way ? '0 : line_way + 1'b1;
                        if (last_way) begin
                            if (last_set) state <= FLUSHED;
                            else          line_idx <= line_idx + 1'b1;
                        end
                    end
                end
                default: state <= FLUSHED;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway (WAYS=2, SETS=8, WORDS=4): a vector table
// of datapath requests plus hand sequences for dwait stalls and flush/reset.
module tb_cache_ctrl_nway;
    logic CLK;
    logic nRST;
    int   checks;
    int   errors;
    int   rd_beats;
    int   wr_beats;
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [31:0] wd_log[$];

    cache_ctrl_nway_if bus();

    cache_ctrl_nway #(.WAYS(2), .SETS(8), .WORDS(4)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    // Memory model: each word's content is its address with a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A0000;
    endfunction

    assign bus.dload = mem_word(bus.daddr);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.dREN && !bus.dwait) begin
                rd_beats++;
                rd_log.push_back(bus.daddr);
            end
            if (bus.dWEN && !bus.dwait) begin
                wr_beats++;
                wr_log.push_back(bus.daddr);
                wd_log.push_back(bus.dstore);
            end
        end
    end

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_load;
        int          exp_lat;
        int          exp_hits;
        int          exp_miss;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Presents one request at posedge+2 and returns cycles until dhit (-1 on timeout).
    task automatic run_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] ld);
        bus.dmemREN   = !wen;
        bus.dmemWEN   = wen;
        bus.dmemaddr  = addr;
        bus.dmemstore = wd;
        lat = -1;
        ld  = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            if (bus.dhit) begin
                lat = c;
                ld  = bus.dmemload;
                break;
            end
        end
        @(posedge CLK); #2;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic reset_dut();
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;
        bus.dwait     = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_dhit",     32'(bus.dhit),    32'd0);
        chk("rst_flushed",  32'(bus.flushed), 32'd0);
        chk("rst_dREN",     32'(bus.dREN),    32'd0);
        chk("rst_dWEN",     32'(bus.dWEN),    32'd0);
        chk("rst_daddr",    bus.daddr,        32'd0);
        chk("rst_dstore",   bus.dstore,       32'd0);
        chk("rst_dmemload", bus.dmemload,     32'd0);
        chk("rst_hits",     bus.hit_count,    32'd0);
        chk("rst_misses",   bus.miss_count,   32'd0);
        @(posedge CLK); #2;
        nRST = 1'b1;
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          rb0;
        int          wb0;
        int          cnt;
        logic [31:0] ld;

        checks   = 0;
        errors   = 0;
        rd_beats = 0;
        wr_beats = 0;

        tbl[0] = '{1'b0, 32'h040, 32'h0,        32'h5A5A0040, 5, 0, 1, 4, 0};
        tbl[1] = '{1'b1, 32'h044, 32'hDEADBEEF, 32'h0,        0, 1, 1, 0, 0};
        tbl[2] = '{1'b0, 32'h044, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 0};
        tbl[3] = '{1'b0, 32'h0C0, 32'h0,        32'h5A5A00C0, 5, 2, 2, 4, 0};
        tbl[4] = '{1'b0, 32'h040, 32'h0,        32'h5A5A0040, 0, 3, 2, 0, 0};
        tbl[5] = '{1'b0, 32'h140, 32'h0,        32'h5A5A0140, 5, 3, 3, 4, 0};
        tbl[6] = '{1'b0, 32'h040, 32'h0,        32'h5A5A0040, 0, 4, 3, 0, 0};
        tbl[7] = '{1'b1, 32'h140, 32'h12345678, 32'h0,        0, 5, 3, 0, 0};
        tbl[8] = '{1'b0, 32'h040, 32'h0,        32'h5A5A0040, 0, 6, 3, 0, 0};
        tbl[9] = '{1'b0, 32'h0C0, 32'h0,        32'h5A5A00C0, 9, 6, 4, 4, 4};

        reset_dut();

        for (int i = 0; i < 10; i++) begin
            rb0 = rd_beats;
            wb0 = wr_beats;
            rd_log.delete();
            wr_log.delete();
            wd_log.delete();
            run_req(tbl[i].wen, tbl[i].addr, tbl[i].wdata, lat, ld);
            chk($sformatf("row%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
            if (!tbl[i].wen) chk($sformatf("row%0d_dmemload", i), ld, tbl[i].exp_load);
            chk($sformatf("row%0d_hit_count", i),  bus.hit_count,  32'(tbl[i].exp_hits));
            chk($sformatf("row%0d_miss_count", i), bus.miss_count, 32'(tbl[i].exp_miss));
            chk($sformatf("row%0d_rd_beats", i), 32'(rd_beats - rb0), 32'(tbl[i].exp_rd));
            chk($sformatf("row%0d_wr_beats", i), 32'(wr_beats - wb0), 32'(tbl[i].exp_wr));
            if (i == 0) begin
                for (int k = 0; k < 4; k++)
                    chk($sformatf("fill0_addr%0d", k), rd_log[k], 32'h40 + 32'(4 * k));
            end
            if (i == 9) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("evict_wb_addr%0d", k), wr_log[k], 32'h140 + 32'(4 * k));
                    chk($sformatf("evict_wb_data%0d", k), wd_log[k],
                        (k == 0) ? 32'h12345678 : mem_word(32'h140 + 32'(4 * k)));
                    chk($sformatf("evict_fill_addr%0d", k), rd_log[k], 32'hC0 + 32'(4 * k));
                end
            end
        end

        // Three-cycle dwait stall on fill beat 2 of a clean miss to set 0.
        rb0 = rd_beats;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h200;
        repeat (3) begin @(posedge CLK); #2; end
        bus.dwait = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("stall_daddr%0d", k), bus.daddr, 32'h208);
            chk($sformatf("stall_dREN%0d", k), 32'(bus.dREN), 32'd1);
            @(posedge CLK); #2;
        end
        bus.dwait = 1'b0;
        cnt = -1;
        for (int c = 6; c < 100; c++) begin
            @(negedge CLK);
            if (bus.dhit) begin
                cnt = c;
                ld  = bus.dmemload;
                break;
            end
        end
        @(posedge CLK); #2;
        bus.dmemREN = 1'b0;
        chk("stall_latency",    32'(cnt), 32'd8);
        chk("stall_dmemload",   ld, 32'h5A5A0200);
        chk("stall_rd_beats",   32'(rd_beats - rb0), 32'd4);
        chk("stall_miss_count", bus.miss_count, 32'd5);

        // Flush with dirty lines in sets 1 and 5.
        reset_dut();
        run_req(1'b1, 32'h10, 32'hA1A1A1A1, lat, ld);
        chk("flush_prep0_latency", 32'(lat), 32'd5);
        run_req(1'b1, 32'h50, 32'hB2B2B2B2, lat, ld);
        chk("flush_prep1_latency", 32'(lat), 32'd5);
        wr_log.delete();
        wd_log.delete();
        bus.halt = 1'b1;
        cnt = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (bus.flushed) begin
                cnt = c;
                break;
            end
        end
        chk("flush_cycles", 32'(cnt), 32'd23);
        chk("flush_wr_beats", 32'(wr_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("flush_addr%0d", k), wr_log[k],
                ((k < 4) ? 32'h10 : 32'h40) + 32'(4 * k));
            chk($sformatf("flush_data%0d", k), wd_log[k],
                (k == 0) ? 32'hA1A1A1A1 :
                (k == 4) ? 32'hB2B2B2B2 :
                mem_word(((k < 4) ? 32'h10 : 32'h40) + 32'(4 * k)));
        end
        @(posedge CLK); #2;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk($sformatf("flushed_sticky%0d", k), 32'(bus.flushed), 32'd1);
            chk($sformatf("flushed_nohit%0d", k), 32'(bus.dhit), 32'd0);
            chk($sformatf("flushed_nomem%0d", k), 32'(bus.dREN | bus.dWEN), 32'd0);
            @(posedge CLK); #2;
        end
        bus.dmemREN = 1'b0;

        // Asynchronous reset while a dirty line is being written back.
        reset_dut();
        run_req(1'b1, 32'h10, 32'hC3C3C3C3, lat, ld);
        bus.halt = 1'b1;
        repeat (3) begin @(posedge CLK); #2; end
        @(negedge CLK);
        chk("midflush_dWEN",  32'(bus.dWEN), 32'd1);
        chk("midflush_daddr", bus.daddr, 32'h10);
        #1;
        nRST = 1'b0;
        #1;
        chk("midflush_rst_dWEN",    32'(bus.dWEN), 32'd0);
        chk("midflush_rst_flushed", 32'(bus.flushed), 32'd0);
        chk("midflush_rst_daddr",   bus.daddr, 32'd0);
        bus.halt = 1'b0;
        @(posedge CLK); #2;
        nRST = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle_dWEN", 32'(bus.dWEN), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised N-way set-associative, write-back, write-allocate data cache controller with integrated tag/data storage. It sits between the datapath memory port and the memory/arbiter port. It generalises the 2-level controller to arbitrary ways, sets and block size, and adds true-LRU replacement, halt-triggered flush of all dirty lines, and hit/miss performance counters.

## Interface
- WAYS, 2, associativity (power of 2, ≥1)
- SETS, 8, sets per way (power of 2, ≥2)
- WORDS, 4, 32-bit words per block (power of 2, ≥2)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- dmemREN / dmemWEN  in  1  datapath read/write request, held until dhit
- dmemaddr  in  32  byte address; [1:0] byte offset, next log2(WORDS) bits blkoff, next log2(SETS) bits idx, rest tag
- dmemstore  in  32  write data
- halt  in  1  request flush; level, sampled only when no request pending
- dhit  out  1  request completed this cycle
- dmemload  out  32  read data, valid when dhit & dmemREN
- flushed  out  1  all dirty lines written back; sticky until reset
- dREN / dWEN  out  1  memory read/write request
- daddr  out  32  memory word address, [1:0]=0
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; beat completes on a cycle with dwait=0
- hit_count / miss_count  out  32  performance counters, wrapping

## Operation
- Storage per (set, way): valid, dirty, tag, WORDS data words, age (log2(WAYS) bits).
- States: COMPARE, WB, FILL, FLUSH, FLUSHED.
- COMPARE: if dmemWEN|dmemREN (WEN wins if both): tag-compare all ways of idx.
  - Hit: dhit=1 combinationally; read drives dmemload from hit word; write stores dmemstore into hit word, sets dirty. LRU touch on hit way.
  - Miss: victim = lowest-index invalid way, else way with age WAYS-1. miss_count++, set internal retry flag. Victim valid&dirty -> WB, else FILL.
  - No request and halt -> FLUSH with set/way pointer at 0.
- LRU touch of way w: every way with age < age[w] increments; age[w]=0. Ages remain a permutation of 0..WAYS-1.
- hit_count++ on dhit when retry flag clear; retry flag clears on any dhit.
- WB: dWEN=1, daddr={victim tag, idx, beat, 2'b00}, dstore=victim word[beat]; beat advances on dwait=0; after beat WORDS-1 completes -> FILL, beat=0.
- FILL: dREN=1, daddr={req tag, idx, beat, 2'b00}; on dwait=0 write dload into victim word[beat]. After last beat: tag written, valid=1, dirty=0 -> COMPARE (request re-evaluated, hits).
- FLUSH: walk sets 0..SETS-1, ways 0..WAYS-1 per set. Valid&dirty line: write back WORDS beats as in WB, then clear dirty. Clean/invalid line: skipped in one cycle. After last line -> FLUSHED.
- FLUSHED: flushed=1, no memory requests, requests ignored (dhit=0) until reset.

## Timing
- Reset (async): state COMPARE, all valid/dirty 0, data 0, ages[way i]=i, counters 0, beat/pointers 0; all outputs 0 (dREN, dWEN, dhit, flushed, daddr, dstore, dmemload).
- Hit latency 0: dhit same cycle as request.
- Clean miss, zero-wait memory: dhit WORDS+1 cycles after request presented; dirty miss: 2·WORDS+1. Each dwait=1 cycle adds one.
- dwait held high indefinitely: stall in current beat, outputs stable.
- daddr/dstore/dREN/dWEN change only on state/beat change; stable while dwait=1.
- Request deasserted mid-miss: WB/FILL still complete; line installed; no dhit.
- halt asserted with request pending: request served first; flush starts next COMPARE with no request.
- Flush of fully clean cache: WAYS·SETS cycles then flushed.

## Test plan
- (WAYS=2,SETS=8,WORDS=4) Read 0x40 after reset -> FILL daddr 0x40,0x44,0x48,0x4C; dhit at cycle 5 with dload[0]; miss_count=1, hit_count=0.
- Write 0x44 data 0xDEADBEEF then read 0x44 -> both hit same cycle, dmemload=0xDEADBEEF, hit_count=2, no memory activity.
- Then read 0xC0, touch 0x40, read 0x140 (all idx 4) -> victim is tag-1 way (clean), FILL only; then read 0x40 still hits.
- Dirty eviction: write 0x140, read 0x40, read 0xC0 -> WB beats 0x140..0x14C with written word at 0x140, then FILL 0xC0..0xCC; dhit at cycle 9.
- dwait=1 for 3 cycles on FILL beat 2 -> daddr held at beat-2 address, dhit delayed by 3 cycles.
- halt with two dirty lines (sets 1 and 5) -> exactly 8 dWEN beats in set order, flushed=1 afterward and stays 1; reset mid-flush -> dWEN drops immediately, flushed=0.
